aes_round_umsk: RTL and testbench
=================================

Name: aes_round_umsk

Overview:
Unmasked (plain) AES-128 single-round datapath with on-the-fly key expansion. Each evaluation applies AddRoundKey, SubBytes, ShiftRows and MixColumns to the input state, and derives the next round key from the input key and RCON. It is the reference and unprotected counterpart of the masked round cores, instantiated by an iterative AES-128 encryption controller.

Parameters:
None.

Ports:
clk  input  1  clock; used only when the output register is compiled in
rst  input  1  synchronous, active-high reset; used only when the output register is compiled in
state_in  input  128  current state, byte n at bits [8n+7:8n]
key_in  input  128  current round key, same byte packing
RCON  input  8  round constant for this key-expansion step
state_out  output  128  MixColumns(ShiftRows(SubBytes(state_in ^ key_in)))
key_out  output  128  next AES-128 round key

Behaviour:
- Byte packing: FIPS-197 byte n (n = 0..15) sits at bits [8n+7:8n].
  - Column c = n/4, row r = n%4.
  - Word w_c = bytes 4c..4c+3, with byte 4c as the MSB in FIPS notation.
- Datapath, pure combinational by default, in this order:
  1. t = state_in XOR key_in.
  2. SubBytes: the standard AES S-box on all 16 bytes. Implement as a 256-entry case/ROM or a GF(2^8) inversion plus affine map; both are acceptable.
  3. ShiftRows: row r rotates left by r columns, i.e. out byte (r, c) = in byte (r, (c+r) mod 4).
  4. MixColumns per column with the matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), modulus x^8+x^4+x^3+x+1. xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - No final-round (MixColumns bypass) mode.
- Key expansion:
  - tmp = SubWord(RotWord(w3)) ^ {RCON, 0, 0, 0}.
  - RotWord moves byte 12 to byte 15's position, i.e. [b13, b14, b15, b12].
  - RCON is XORed into byte 12 position after rotation, which lands in key_out byte 0.
  - w0' = w0 ^ tmp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- Any RCON value is accepted verbatim; no validity check is performed. RCON = 0 gives plain expansion with no constant.
- Default build: zero latency. Outputs settle within the same delta after inputs change; clk and rst are ignored.
- No X-propagation masking: X on any input may appear on the outputs.

Optional Feature:
Macro AES_ROUND_UMSK_OUTREG_EN.
- Defined:
  - state_out and key_out are registered on the rising edge of clk; latency is exactly 1 cycle.
  - rst high at an edge clears both outputs to 128'h0 on that edge, overriding the new data.
  - Reset mid-stream discards the in-flight result. The first valid output appears one edge after rst deasserts with valid inputs.
- Not defined: purely combinational, as described above.

Test Plan:
1. FIPS-197 round 1, all outputs settling within 1 time unit:
   - Stimulus: key_in = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, state_in = 128'h340737e0_a2983131_8d305a88_a8f64332, RCON = 8'h01.
   - Required: state_out = 128'h4c260628_7ad3f848_9a19cbe0_e5816604 and key_out = 128'h05766c2a_3939a323_b12c5488_17fefaa0.
2. All-zero key and state, RCON = 8'h01:
   - state_out = 128'h63636363_63636363_63636363_63636363.
   - key_out = 128'h63636362_63636362_63636362_63636362.
3. All-zero key and state, RCON = 8'h00 -> key_out = all bytes 8'h63; state_out as in scenario 2.
4. Chaining: feed key_out of scenario 1 back as key_in with RCON = 8'h02.
   - FIPS round key 2 is a0fafe17 88542cb1 23a33939 2a6c7605 -> f2c295f2 7a96b943 5935807a 7359f67f.
   - Required: key_out = 128'h7ff65973_7a803559_43b9967a_f295c2f2.
5. With AES_ROUND_UMSK_OUTREG_EN defined:
   - Apply scenario 1 with rst = 1 for 2 edges -> outputs 0.
   - Deassert rst -> outputs take the scenario 1 values after exactly 1 edge.
   - Assert rst again -> outputs 0 at the next edge.

Source files
------------

// File: rtl/aes_round_umsk.sv
// Unmasked AES-128 round (AddRoundKey, SubBytes, ShiftRows, MixColumns) with on-the-fly key expansion.
// Define AES_ROUND_UMSK_OUTREG_EN to register both outputs (1-cycle latency, synchronous reset).
module aes_round_umsk (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   RCON,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] state_d;
    logic [127:0] key_d;
    logic [31:0]  tmp;
    logic [31:0]  w0n, w1n, w2n, w3n;

    always_comb begin
        state_d = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            sb[n] = SBOX[state_in[8*n +: 8] ^ key_in[8*n +: 8]];
        end
        // Byte (row r, col c) lives at index 4c+r; row r takes its byte from column c+r.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            state_d[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            state_d[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            state_d[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            state_d[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // RotWord of w3 is [b13, b14, b15, b12]; RCON joins the byte that lands in key_out byte 0.
    always_comb begin
        tmp = {SBOX[key_in[103:96]], SBOX[key_in[127:120]],
               SBOX[key_in[119:112]], SBOX[key_in[111:104]] ^ RCON};
        w0n = key_in[31:0]   ^ tmp;
        w1n = key_in[63:32]  ^ w0n;
        w2n = key_in[95:64]  ^ w1n;
        w3n = key_in[127:96] ^ w2n;
        key_d = {w3n, w2n, w1n, w0n};
    end

`ifdef AES_ROUND_UMSK_OUTREG_EN
    logic [127:0] state_q;
    logic [127:0] key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign state_out = state_q;
    assign key_out   = key_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign state_out = state_d;
    assign key_out   = key_d;
`endif

endmodule

// File: tb/tb_aes_round_umsk.sv
// Directed bench for aes_round_umsk; honours AES_ROUND_UMSK_OUTREG_EN for the registered build.
module tb_aes_round_umsk;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] state_in = '0;
    logic [127:0] key_in = '0;
    logic [7:0]   RCON = '0;
    logic [127:0] state_out;
    logic [127:0] key_out;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] K1  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] S1  = 128'h340737e0_a2983131_8d305a88_a8f64332;
    localparam logic [127:0] SO1 = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
    localparam logic [127:0] KO1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] ALL63 = 128'h63636363_63636363_63636363_63636363;

    aes_round_umsk dut (
        .clk       (clk),
        .rst       (rst),
        .state_in  (state_in),
        .key_in    (key_in),
        .RCON      (RCON),
        .state_out (state_out),
        .key_out   (key_out)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc);
        state_in = s;
        key_in   = k;
        RCON     = rc;
`ifdef AES_ROUND_UMSK_OUTREG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply('0, '0, 8'h01);
        checks++;
`ifdef AES_ROUND_UMSK_OUTREG_EN
        if (state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", state_out, 128'h0);
        end
`else
        if (state_out !== ALL63) begin
            errors++;
            $display("FAIL reset_ignored: got %h want %h", state_out, ALL63);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fips_round1();
        apply(S1, K1, 8'h01);
        checks++;
        if (state_out !== SO1) begin
            errors++;
            $display("FAIL fips_state: got %h want %h", state_out, SO1);
        end
        checks++;
        if (key_out !== KO1) begin
            errors++;
            $display("FAIL fips_key: got %h want %h", key_out, KO1);
        end
    endtask

    task automatic test_zero_vectors();
        apply('0, '0, 8'h01);
        checks++;
        if (state_out !== ALL63) begin
            errors++;
            $display("FAIL zero_rc1_state: got %h want %h", state_out, ALL63);
        end
        checks++;
        if (key_out !== 128'h63636362_63636362_63636362_63636362) begin
            errors++;
            $display("FAIL zero_rc1_key: got %h want %h", key_out, 128'h63636362_63636362_63636362_63636362);
        end
        apply('0, '0, 8'h00);
        checks++;
        if (state_out !== ALL63) begin
            errors++;
            $display("FAIL zero_rc0_state: got %h want %h", state_out, ALL63);
        end
        checks++;
        if (key_out !== ALL63) begin
            errors++;
            $display("FAIL zero_rc0_key: got %h want %h", key_out, ALL63);
        end
        apply('0, '0, 8'hff);
        checks++;
        if (key_out !== 128'h6363639c_6363639c_6363639c_6363639c) begin
            errors++;
            $display("FAIL zero_rcff_key: got %h want %h", key_out, 128'h6363639c_6363639c_6363639c_6363639c);
        end
    endtask

    task automatic test_chaining();
        // state_in == key_in zeroes AddRoundKey so state_out is known without the FIPS state.
        apply(KO1, KO1, 8'h02);
        checks++;
        if (key_out !== 128'h7ff65973_7a803559_43b9967a_f295c2f2) begin
            errors++;
            $display("FAIL chain_key: got %h want %h", key_out, 128'h7ff65973_7a803559_43b9967a_f295c2f2);
        end
        checks++;
        if (state_out !== ALL63) begin
            errors++;
            $display("FAIL chain_state: got %h want %h", state_out, ALL63);
        end
    endtask

    task automatic test_ones_key();
        apply('1, '1, 8'h00);
        checks++;
        if (key_out !== 128'h16161616_e9e9e9e9_16161616_e9e9e9e9) begin
            errors++;
            $display("FAIL ones_rc0_key: got %h want %h", key_out, 128'h16161616_e9e9e9e9_16161616_e9e9e9e9);
        end
        checks++;
        if (state_out !== ALL63) begin
            errors++;
            $display("FAIL ones_state: got %h want %h", state_out, ALL63);
        end
        apply('1, '1, 8'h80);
        checks++;
        if (key_out !== 128'h16161696_e9e9e969_16161696_e9e9e969) begin
            errors++;
            $display("FAIL ones_rc80_key: got %h want %h", key_out, 128'h16161696_e9e9e969_16161696_e9e9e969);
        end
    endtask

    task automatic test_shiftrows_mixcol();
        apply(128'h1, '0, 8'h00);
        checks++;
        if (state_out !== 128'h63636363_63636363_63636363_427c7c5d) begin
            errors++;
            $display("FAIL byte0_state: got %h want %h", state_out, 128'h63636363_63636363_63636363_427c7c5d);
        end
        apply(128'h01 << 40, '0, 8'h00);
        checks++;
        if (state_out !== 128'h63636363_63636363_63636363_7c7c5d42) begin
            errors++;
            $display("FAIL byte5_state: got %h want %h", state_out, 128'h63636363_63636363_63636363_7c7c5d42);
        end
    endtask

`ifdef AES_ROUND_UMSK_OUTREG_EN
    task automatic test_outreg();
        rst = 1'b1;
        state_in = S1;
        key_in   = K1;
        RCON     = 8'h01;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (state_out !== 128'h0 || key_out !== 128'h0) begin
            errors++;
            $display("FAIL outreg_rst_hold: got %h/%h want 0/0", state_out, key_out);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state_out !== SO1) begin
            errors++;
            $display("FAIL outreg_state_1edge: got %h want %h", state_out, SO1);
        end
        checks++;
        if (key_out !== KO1) begin
            errors++;
            $display("FAIL outreg_key_1edge: got %h want %h", key_out, KO1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state_out !== 128'h0 || key_out !== 128'h0) begin
            errors++;
            $display("FAIL outreg_rst_again: got %h/%h want 0/0", state_out, key_out);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_fips_round1();
        test_zero_vectors();
        test_chaining();
        test_ones_key();
        test_shiftrows_mixcol();
`ifdef AES_ROUND_UMSK_OUTREG_EN
        test_outreg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
